// File: rtl/mem_port_arbiter_if.sv
// Signal bundle shared by the IF/D core stages, the memory port arbiter and the memory slave.
interface mem_port_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_gnt;
    logic                if_rvalid;
    logic [WIDTH-1:0]    if_rdata;
    logic                if_err;

    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [WIDTH-1:0]    d_wdata;
    logic [WIDTH/8-1:0]  d_wstrb;
    logic                d_gnt;
    logic                d_rvalid;
    logic [WIDTH-1:0]    d_rdata;
    logic                d_err;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [WIDTH/8-1:0]  mem_wstrb;
    logic                mem_ack;
    logic [WIDTH-1:0]    mem_rdata;

    logic                busy;

    // The arbiter drives grants, responses and the memory request.
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// one outstanding access at a time, with an ack timeout that returns an error response.
module mem_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam int STRB_W = WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, ACCESS} state_e;
    typedef enum logic {OWN_IF, OWN_D} owner_e;

    state_e             state_q, state_d;
    owner_e             last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               if_gnt_q, if_gnt_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic [WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic               if_err_q, if_err_d;
    logic               d_gnt_q, d_gnt_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic [WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic               d_err_q, d_err_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]  mem_wstrb_q, mem_wstrb_d;

    logic               expire;
    logic [WIDTH-1:0]   resp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_D;
            cnt_q        <= '0;
            if_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            if_err_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= '0;
            d_err_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            if_gnt_q     <= if_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            d_gnt_q      <= d_gnt_d;
            d_rvalid_q   <= d_rvalid_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
        end
    end

    // Ack wins over expiry; a timed-out or write access returns zero data.
    assign expire    = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign resp_data = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        if_gnt_d     = 1'b0;
        if_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        if_err_d     = if_err_q;
        d_gnt_d      = 1'b0;
        d_rvalid_d   = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_err_d      = d_err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;

        case (state_q)
            IDLE: begin
                // On a tie the requester that did not own the previous access wins.
                if (bus.if_req && (!bus.d_req || last_owner_q == OWN_D)) begin
                    state_d      = ACCESS;
                    last_owner_d = OWN_IF;
                    cnt_d        = '0;
                    if_gnt_d     = 1'b1;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = bus.if_addr;
                    mem_wdata_d  = '0;
                    mem_wstrb_d  = '0;
                end else if (bus.d_req) begin
                    state_d      = ACCESS;
                    last_owner_d = OWN_D;
                    cnt_d        = '0;
                    d_gnt_d      = 1'b1;
                    mem_req_d    = 1'b1;
                    mem_we_d     = bus.d_we;
                    mem_addr_d   = bus.d_addr;
                    mem_wdata_d  = bus.d_wdata;
                    mem_wstrb_d  = bus.d_wstrb;
                end
            end
            ACCESS: begin
                if (bus.mem_ack || expire) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (last_owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = resp_data;
                        if_err_d    = !bus.mem_ack;
                    end else begin
                        d_rvalid_d  = 1'b1;
                        d_rdata_d   = resp_data;
                        d_err_d     = !bus.mem_ack;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.busy      = (state_q == ACCESS);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single accesses plus hand-written tie, reset and idle-ack
// sequences; responses are predicted into a queue and compared when rvalid appears.
module tb_mem_port_arbiter;
    localparam int WIDTH   = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          isD;
        logic [31:0] rdata;
        bit          err;
    } resp_t;

    typedef struct {
        bit          isD;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;
        logic [31:0] memRdata;
        logic [31:0] expRdata;
        bit          expErr;
    } vec_t;

    resp_t expQ[$];
    vec_t  vecs[8];
    int    checks = 0;
    int    errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input bit isD, input logic [31:0] rdata, input bit err);
        resp_t r;
        r.isD   = isD;
        r.rdata = rdata;
        r.err   = err;
        expQ.push_back(r);
    endtask

    // Scoreboard: every response pulse must match the oldest prediction.
    always @(negedge clk) begin
        resp_t e;
        if (!rst && (bus.if_rvalid || bus.d_rvalid)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedRvalid: got if_rvalid=%0b d_rvalid=%0b, expected none",
                         bus.if_rvalid, bus.d_rvalid);
            end else begin
                e = expQ.pop_front();
                checkOutput("rvalidSide", {bus.if_rvalid, bus.d_rvalid}, e.isD ? 2'b01 : 2'b10);
                checkOutput("rdata", e.isD ? bus.d_rdata : bus.if_rdata, e.rdata);
                checkOutput("err", e.isD ? bus.d_err : bus.if_err, e.err);
            end
        end
    end

    task automatic idleInputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_wstrb   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Flags"}, {bus.if_gnt, bus.if_rvalid, bus.if_err, bus.d_gnt, bus.d_rvalid,
                                     bus.d_err, bus.mem_req, bus.mem_we, bus.busy, bus.mem_wstrb}, '0);
        checkOutput({tag, "Rdata"}, {bus.if_rdata, bus.d_rdata}, '0);
        checkOutput({tag, "MemBus"}, {bus.mem_addr, bus.mem_wdata}, '0);
    endtask

    task automatic waitGrant(input bit expD);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(bus.if_gnt || bus.d_gnt) && lat < 8);
        checkOutput("gntSide", {bus.if_gnt, bus.d_gnt}, expD ? 2'b01 : 2'b10);
        checkOutput("gntLatency", lat, 1);
    endtask

    task automatic checkMem(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        checkOutput("memReqBusy", {bus.mem_req, bus.busy}, 2'b11);
        checkOutput("memCtrl", {bus.mem_we, bus.mem_wstrb, bus.mem_addr}, {we, wstrb, addr});
        checkOutput("memWdata", bus.mem_wdata, wdata);
    endtask

    // Plays the memory: acks `delay` cycles after the grant was seen, then waits for the response.
    task automatic serveAccess(input int delay, input logic [31:0] memRdata, input bit we,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        int k      = 0;
        bit seen   = 0;
        bit stable = 1;
        int expLat = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
        while (!seen && k < 40) begin
            bus.mem_ack   = (k == delay);
            bus.mem_rdata = memRdata;
            @(negedge clk);
            k++;
            if (bus.if_rvalid || bus.d_rvalid)
                seen = 1;
            else if (!(bus.mem_req && bus.busy && !bus.if_gnt && !bus.d_gnt && bus.mem_we == we &&
                       bus.mem_addr == addr && bus.mem_wdata == wdata && bus.mem_wstrb == wstrb))
                stable = 0;
        end
        bus.mem_ack = 1'b0;
        checkOutput("rvalidLatency", k, expLat);
        checkOutput("memStable", stable, 1);
        checkOutput("idleAfterResp", {bus.mem_req, bus.busy}, 2'b00);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.if_req  = !v.isD;
        bus.if_addr = v.addr;
        bus.d_req   = v.isD;
        bus.d_we    = v.isD ? v.we : 1'b1;
        bus.d_addr  = v.isD ? v.addr : 32'hFFFF_FFF0;
        bus.d_wdata = v.isD ? v.wdata : 32'hFFFF_FFFF;
        bus.d_wstrb = v.isD ? v.wstrb : 4'hF;
        waitGrant(v.isD);
        if (v.isD) checkMem(v.we, v.addr, v.wdata, v.wstrb);
        else       checkMem(1'b0, v.addr, 32'h0, 4'h0);
        pushExp(v.isD, v.expRdata, v.expErr);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        if (v.isD) serveAccess(v.delay, v.memRdata, v.we, v.addr, v.wdata, v.wstrb);
        else       serveAccess(v.delay, v.memRdata, 1'b0, v.addr, 32'h0, 4'h0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] tieRdata;
        bit          expD;

        //                isD we addr           wdata          wstrb delay  memRdata       expRdata       expErr
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 2,     32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 3,     32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         4'h0, 0,     32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0304, 32'h0,         4'h0, NEVER, 32'h1111_2222, 32'h0,         1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0308, 32'h0,         4'h0, 14,    32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'h0, 15,    32'h3333_4444, 32'h0,         1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 0,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_03FC, 32'h8765_4321, 4'hF, 5,     32'h5555_6666, 32'h0,         1'b0};

        rst = 1'b1;
        idleInputs();
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
        checkOutput("ifRdataHeld", {bus.if_err, bus.if_rdata}, {1'b0, 32'hFFFF_FFFF});

        // Abort an IF access with reset; last_owner must return to D so IF wins the next tie.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0600;
        waitGrant(1'b0);
        bus.if_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midReset");
        rst = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("lateAckQuiet", {bus.if_rvalid, bus.d_rvalid, bus.busy, bus.mem_req}, 4'h0);
            @(negedge clk);
        end

        // Both held high: grants alternate IF, D, IF, D.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0500;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0400;
        bus.d_wdata = 32'h1122_3344;
        bus.d_wstrb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            expD     = (i % 2) == 1;
            tieRdata = 32'h5000_0000 + 32'(i);
            waitGrant(expD);
            if (expD) begin
                checkMem(1'b1, 32'h0000_0400, 32'h1122_3344, 4'hF);
                pushExp(1'b1, 32'h0, 1'b0);
                serveAccess(1, tieRdata, 1'b1, 32'h0000_0400, 32'h1122_3344, 4'hF);
            end else begin
                checkMem(1'b0, 32'h0000_0500, 32'h0, 4'h0);
                pushExp(1'b0, tieRdata, 1'b0);
                serveAccess(1, tieRdata, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
            end
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);

        // Stray acks while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h9999_0000 + 32'(i);
            @(negedge clk);
            bus.mem_ack = 1'b0;
            @(negedge clk);
            checkOutput("idleAckIgnored", {bus.if_rvalid, bus.d_rvalid, bus.busy, bus.mem_req}, 4'h0);
        end

        checkOutput("queueDrained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
